// File: rtl/game_pkg.sv
// Shared types for the 3x3 board game: cell codes, board layout and the turn FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Indexed as board[row][col], both 1..3.
  typedef cell_t [3:1][3:1] board_t;

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StTimeout,
    StCheck,
    StOver
  } tc_state_t;

  typedef struct packed {
    logic [1:0] y;
    logic [1:0] x;
  } pos_t;

endpackage

// File: rtl/win_checker.sv
// Combinational board evaluation: does the given player own a full line, and is every cell taken.
module win_checker
  import game_pkg::*;
(
  input  board_t board,
  input  cell_t  player,
  output logic   line_win,
  output logic   board_full
);

  always_comb begin
    line_win   = 1'b0;
    board_full = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      if (board[r][1] == player && board[r][2] == player && board[r][3] == player) begin
        line_win = 1'b1;
      end
      if (board[1][r] == player && board[2][r] == player && board[3][r] == player) begin
        line_win = 1'b1;
      end
      for (int c = 1; c <= 3; c++) begin
        if (board[r][c] == EMPTY) begin
          board_full = 1'b0;
        end
      end
    end
    if (board[1][1] == player && board[2][2] == player && board[3][3] == player) begin
      line_win = 1'b1;
    end
    if (board[1][3] == player && board[2][2] == player && board[3][1] == player) begin
      line_win = 1'b1;
    end
    // An empty line must never count as a win.
    if (player == EMPTY) begin
      line_win = 1'b0;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Game sequencer: owns the board, alternates P1/P2 turns, runs the turn timer with auto-play
// fallback, and declares a winner or a draw.
module turn_controller
  import game_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move,
  input  logic       attack,
  input  logic [1:0] row,
  input  logic [1:0] col,
  input  logic       end_attack_p1,
  input  logic       end_attack_p2,
  output logic       en_attack_p1,
  output logic       en_attack_p2,
  output logic       timeout,
  output logic [1:0] rand_x,
  output logic [1:0] rand_y,
  output board_t     board,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned TimerW = $clog2(TURN_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TURN_CYCLES - 1);

  tc_state_t         state_q, state_d;
  cell_t             player_q, player_d;
  board_t            board_q, board_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        rand_x_q, rand_x_d;
  logic [1:0]        rand_y_q, rand_y_d;
  pos_t              rand_q, rand_d;
  logic              manual_q, manual_d;
  logic              game_over_q, game_over_d;
  cell_t             winner_q, winner_d;

  logic       line_win, board_full;
  logic       ack, in_play, tgt_allowed, accept;
  logic [1:0] tgt_row, tgt_col;

  win_checker u_win_checker (
    .board      (board_q),
    .player     (player_q),
    .line_win   (line_win),
    .board_full (board_full)
  );

  // Free-running scan of auto-play candidates plus the delayed copy used on timeout.
  always_comb begin
    rand_x_d = (rand_x_q == 2'd3) ? 2'd1 : rand_x_q + 2'd1;
    rand_y_d = rand_y_q;
    if (rand_x_q == 2'd3) begin
      rand_y_d = (rand_y_q == 2'd3) ? 2'd1 : rand_y_q + 2'd1;
    end
    rand_d.y = rand_y_q;
    rand_d.x = rand_x_q;
    manual_d = attack & ~move;
  end

  // Decide whether this cycle's acknowledge lands on the board, and where.
  always_comb begin
    ack = ((player_q == P1) & end_attack_p1) | ((player_q == P2) & end_attack_p2);
    in_play     = (state_q == StTurn) | (state_q == StTimeout);
    tgt_row     = manual_q ? row : rand_q.y;
    tgt_col     = manual_q ? col : rand_q.x;
    tgt_allowed = manual_q | (state_q == StTimeout);
    accept = in_play & ack & tgt_allowed & (tgt_row != 2'd0) & (tgt_col != 2'd0) &
             (board_q[tgt_row][tgt_col] == EMPTY);
  end

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    board_d     = board_q;
    timer_d     = timer_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          board_d     = '0;
          player_d    = P1;
          game_over_d = 1'b0;
          winner_d    = EMPTY;
          timer_d     = '0;
          state_d     = StTurn;
        end
      end
      StTurn: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TimerLast) begin
          state_d = StTimeout;
        end
        if (accept) begin
          board_d[tgt_row][tgt_col] = player_q;
          state_d = StCheck;
        end
      end
      StTimeout: begin
        if (accept) begin
          board_d[tgt_row][tgt_col] = player_q;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (line_win) begin
          game_over_d = 1'b1;
          winner_d    = player_q;
          state_d     = StOver;
        end else if (board_full) begin
          game_over_d = 1'b1;
          winner_d    = EMPTY;
          state_d     = StOver;
        end else begin
          player_d = (player_q == P1) ? P2 : P1;
          timer_d  = '0;
          state_d  = StTurn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      player_q    <= P1;
      board_q     <= '0;
      timer_q     <= '0;
      rand_x_q    <= 2'd1;
      rand_y_q    <= 2'd1;
      rand_q      <= '{y: 2'd1, x: 2'd1};
      manual_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= EMPTY;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      board_q     <= board_d;
      timer_q     <= timer_d;
      rand_x_q    <= rand_x_d;
      rand_y_q    <= rand_y_d;
      rand_q      <= rand_d;
      manual_q    <= manual_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign en_attack_p1 = in_play & (player_q == P1);
  assign en_attack_p2 = in_play & (player_q == P2);
  assign timeout      = (state_q == StTimeout);
  assign rand_x       = rand_x_q;
  assign rand_y       = rand_y_q;
  assign board        = board_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule
